// File: rtl/fifo_drain_pkg.sv
// Shared types and defaults for the FIFO read-side drain controller.
// Optional build macro DRAIN_GAP_EN adds the GAP state and widens the encoding.
package fifo_drain_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

`ifdef DRAIN_GAP_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_DONE = 3'd2,
    DROP      = 3'd3,
    GAP       = 3'd4
  } drain_state_e;
`else
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    DROP      = 2'd3
  } drain_state_e;
`endif

endpackage

// File: rtl/fifo_drain_gap_cnt.sv
// Loadable down-counter that times the idle gap between transmitted words.
// done_o flags the last gap cycle (count of 1) so the FSM can leave on time.
module fifo_drain_gap_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] cfg_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = cfg_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side sequencer: pops one FIFO word per transfer and hands it to the UART TX.
// Build macro DRAIN_GAP_EN adds GAP_CFG and a programmable gap after each word.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
`ifdef DRAIN_GAP_EN
  , parameter int unsigned GAP_WIDTH = 4
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  FLUSH,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  input  logic                  TX_BUSY,
`ifdef DRAIN_GAP_EN
  input  logic [GAP_WIDTH-1:0]  GAP_CFG,
`endif
  output logic                  FIFO_R_INC,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_DATA_VALID,
  output logic                  CTRL_BUSY
);

  drain_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rinc_q, rinc_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

`ifdef DRAIN_GAP_EN
  logic gap_load;
  logic gap_done;

  fifo_drain_gap_cnt #(
    .WIDTH (GAP_WIDTH)
  ) u_gap_cnt (
    .clk_i   (CLK),
    .rst_n_i (RST),
    .load_i  (gap_load),
    .cfg_i   (GAP_CFG),
    .dec_i   (state_q == GAP),
    .done_o  (gap_done)
  );
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rinc_d  = 1'b0;
    valid_d = valid_q;
`ifdef DRAIN_GAP_EN
    gap_load = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (FLUSH && !FIFO_EMPTY) begin
          rinc_d  = 1'b1;
          state_d = DROP;
        end else if (EN && !FIFO_EMPTY) begin
          // Capture and pop on the same edge: read data is valid while not empty.
          data_d  = FIFO_RD_DATA;
          rinc_d  = 1'b1;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        valid_d = 1'b1;
        if (TX_BUSY) begin
          valid_d = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          state_d = IDLE;
`ifdef DRAIN_GAP_EN
          if (GAP_CFG != '0) begin
            gap_load = 1'b1;
            state_d  = GAP;
          end
`endif
        end
      end
      DROP: begin
        state_d = IDLE;
      end
`ifdef DRAIN_GAP_EN
      GAP: begin
        if (gap_done) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      rinc_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rinc_q  <= rinc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign FIFO_R_INC    = rinc_q;
  assign TX_DATA       = data_q;
  assign TX_DATA_VALID = valid_q;
  assign CTRL_BUSY     = busy_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl with a FIFO model, a TX model and a scoreboard.
// Define DRAIN_GAP_EN to exercise the inter-word gap feature as well.
module tb_fifo_drain_ctrl;

  localparam int unsigned DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          EN;
  logic          FLUSH;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_r_inc;
  logic          tx_busy;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          ctrl_busy;
`ifdef DRAIN_GAP_EN
  logic [3:0]    gap_cfg;
`endif

  always #5 CLK = ~CLK;

  fifo_drain_ctrl #(
    .DATA_WIDTH (DW)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .EN            (EN),
    .FLUSH         (FLUSH),
    .FIFO_EMPTY    (fifo_empty),
    .FIFO_RD_DATA  (fifo_rd_data),
    .TX_BUSY       (tx_busy),
`ifdef DRAIN_GAP_EN
    .GAP_CFG       (gap_cfg),
`endif
    .FIFO_R_INC    (fifo_r_inc),
    .TX_DATA       (tx_data),
    .TX_DATA_VALID (tx_valid),
    .CTRL_BUSY     (ctrl_busy)
  );

  // FIFO model: pops on an edge where R_INC is high, EMPTY follows one edge later.
  logic [DW-1:0] mem [0:255];
  logic [7:0]    rd_ptr = '0;
  logic [7:0]    wr_ptr;
  assign fifo_empty   = (rd_ptr == wr_ptr);
  assign fifo_rd_data = mem[rd_ptr];

  always @(posedge CLK) begin
    if (fifo_r_inc) rd_ptr <= rd_ptr + 8'd1;
  end

  // TX model: accepts a word when idle, raises busy next cycle for busy_len cycles.
  int unsigned   busy_len;
  int unsigned   bcnt;
  logic [DW-1:0] got_q[$];

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end else if (tx_busy) begin
      if (bcnt == 1) tx_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end else if (tx_valid) begin
      got_q.push_back(tx_data);
      tx_busy <= 1'b1;
      bcnt    <= busy_len;
    end
  end

  // Activity monitor.
  int   cyc = 0;
  int   pop_cyc[$];
  int   fall_cyc[$];
  int   dbl = 0;
  int   valid_cnt = 0;
  logic prev_rinc = 1'b0;
  logic prev_busy = 1'b0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (fifo_r_inc) begin
      pop_cyc.push_back(cyc);
      if (prev_rinc) dbl <= dbl + 1;
    end
    if (prev_busy && !tx_busy) fall_cyc.push_back(cyc);
    if (tx_valid) valid_cnt <= valid_cnt + 1;
    prev_rinc <= fifo_r_inc;
    prev_busy <= tx_busy;
  end

  int            nerrs = 0;
  int            nchecks = 0;
  logic [DW-1:0] exp_q[$];
  int            got_idx = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic drain_tx(input string nm);
    logic [DW-1:0] e;
    while (got_idx < got_q.size()) begin
      if (exp_q.size() == 0) begin
        nchecks++;
        nerrs++;
        $display("FAIL %s_tx_unexpected: got %0h expected no word", nm, got_q[got_idx]);
      end else begin
        e = exp_q.pop_front();
        chk({nm, "_tx_data"}, 32'(got_q[got_idx]), 32'(e));
      end
      got_idx++;
    end
    chk({nm, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input string nm);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 400) begin
      @(negedge CLK);
      n++;
      if (!ctrl_busy && !tx_valid && !tx_busy && !fifo_r_inc) quiet++;
      else quiet = 0;
    end
    chk({nm, "_idle"}, 32'(quiet >= 3), 32'd1);
  endtask

  task automatic run_gap(input logic [3:0] g);
    int s;
    int f;
    busy_len = 3;
`ifdef DRAIN_GAP_EN
    gap_cfg = g;
`endif
    s = pop_cyc.size();
    f = fall_cyc.size();
    push(8'hC1); exp_q.push_back(8'hC1);
    push(8'hC2); exp_q.push_back(8'hC2);
    @(negedge CLK);
    EN = 1'b1;
    wait_idle("E");
    EN = 1'b0;
    if (pop_cyc.size() >= s + 2 && fall_cyc.size() > f)
      chk("E_gap_timing", 32'(pop_cyc[s+1] - fall_cyc[f]), 32'd2 + 32'(g));
    else
      chk("E_gap_events", 32'(pop_cyc.size() - s), 32'd2);
    drain_tx("E");
  endtask

  typedef struct {
    logic          en;
    logic          flush;
    logic          load;
    logic [DW-1:0] data;
    logic          exp_rinc;
    logic          exp_valid;
    logic          exp_busy;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int s;
    int v;
    int n;
    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF};

    RST = 1'b0; EN = 1'b0; FLUSH = 1'b0; wr_ptr = '0; busy_len = 2;
`ifdef DRAIN_GAP_EN
    gap_cfg = '0;
`endif

    // Decision table out of a fresh reset.
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("rst_outputs", {21'd0, fifo_r_inc, tx_valid, ctrl_busy, tx_data}, 32'd0);
      wr_ptr = rd_ptr;
      if (vecs[i].load) push(vecs[i].data);
      EN = vecs[i].en;
      FLUSH = vecs[i].flush;
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].exp_data);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("vec_rinc",  32'(fifo_r_inc), 32'(vecs[i].exp_rinc));
      chk("vec_valid", 32'(tx_valid),   32'(vecs[i].exp_valid));
      chk("vec_busy",  32'(ctrl_busy),  32'(vecs[i].exp_busy));
      chk("vec_data",  32'(tx_data),    32'(vecs[i].exp_data));
      EN = 1'b0;
      FLUSH = 1'b0;
      wait_idle("vec");
      drain_tx("vec");
    end
    wr_ptr = rd_ptr;

    // A: three back-to-back words with a 10-cycle busy.
    busy_len = 10;
    s = pop_cyc.size();
    push(8'h11); exp_q.push_back(8'h11);
    push(8'h22); exp_q.push_back(8'h22);
    push(8'h33); exp_q.push_back(8'h33);
    @(negedge CLK);
    EN = 1'b1;
    n = 0;
    while (!tx_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("A_valid_seen", 32'(tx_valid), 32'd1);
    chk("A_first_data", 32'(tx_data), 32'h11);
    @(negedge CLK);
    chk("A_valid_hold", {30'd0, tx_valid, tx_busy}, 32'h3);
    @(negedge CLK);
    chk("A_valid_clear", 32'(tx_valid), 32'd0);
    wait_idle("A");
    EN = 1'b0;
    chk("A_pops", 32'(pop_cyc.size() - s), 32'd3);
    chk("A_ctrl_busy", 32'(ctrl_busy), 32'd0);
    drain_tx("A");

    // B: flush five words.
    s = pop_cyc.size();
    v = valid_cnt;
    for (int k = 0; k < 5; k++) push(8'hA0 + 8'(k));
    @(negedge CLK);
    FLUSH = 1'b1;
    EN = 1'b1;
    wait_idle("B");
    FLUSH = 1'b0;
    EN = 1'b0;
    chk("B_pops", 32'(pop_cyc.size() - s), 32'd5);
    for (int k = 1; k < 5; k++)
      if (pop_cyc.size() > s + k)
        chk("B_spacing", 32'(pop_cyc[s+k] - pop_cyc[s+k-1]), 32'd2);
    chk("B_no_valid", 32'(valid_cnt - v), 32'd0);
    chk("B_tx_data", 32'(tx_data), 32'h33);
    chk("B_empty", 32'(fifo_empty), 32'd1);
    drain_tx("B");

    // C: EN dropped while SEND is in progress.
    busy_len = 4;
    s = pop_cyc.size();
    push(8'h7E); exp_q.push_back(8'h7E);
    @(negedge CLK);
    EN = 1'b1;
    @(negedge CLK);
    chk("C_valid", 32'(tx_valid), 32'd1);
    chk("C_data", 32'(tx_data), 32'h7E);
    EN = 1'b0;
    push(8'h55);
    wait_idle("C");
    chk("C_pops", 32'(pop_cyc.size() - s), 32'd1);
    chk("C_left", 32'(fifo_empty), 32'd0);
    drain_tx("C");
    wr_ptr = rd_ptr;

    // D: reset while waiting for the transmitter.
    busy_len = 10;
    push(8'h9C); exp_q.push_back(8'h9C);
    @(negedge CLK);
    EN = 1'b1;
    n = 0;
    while (!(tx_busy && !tx_valid && ctrl_busy) && n < 30) begin
      @(negedge CLK);
      n++;
    end
    chk("D_wait_done", 32'(tx_busy && !tx_valid && ctrl_busy), 32'd1);
    push(8'h4B);
    #2;
    RST = 1'b0;
    #1;
    chk("D_async_rst", {21'd0, fifo_r_inc, tx_valid, ctrl_busy, tx_data}, 32'd0);
    @(negedge CLK);
    exp_q.push_back(8'h4B);
    RST = 1'b1;
    @(negedge CLK);
    chk("D_rinc", 32'(fifo_r_inc), 32'd1);
    chk("D_data", 32'(tx_data), 32'h4B);
    chk("D_valid", 32'(tx_valid), 32'd1);
    EN = 1'b0;
    wait_idle("D");
    drain_tx("D");

    // E: spacing between busy falling and the next pop.
`ifdef DRAIN_GAP_EN
    run_gap(4'd3);
`endif
    run_gap(4'd0);

    chk("no_double_pop", 32'(dbl), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule

// File: doc/fifo_drain_ctrl.md
Name: fifo_drain_ctrl

Overview:
- Read-side sequencer for the dual-clock FIFO, running in the FIFO read clock domain.
- Detects a non-empty FIFO, pops exactly one word per transfer, holds it in a register and hands it to a serial transmitter over a valid/busy handshake.
- Supports a flush mode that discards FIFO contents without transmitting.
- Sits between the FIFO read port (RD_DATA / EMPTY / R_INC) and the UART TX data interface.

Parameters:
- DATA_WIDTH, 8, width of FIFO word and TX data.
- GAP_WIDTH, 4, width of the inter-word gap counter (optional feature only).

Ports:
- CLK  input  1  read-domain clock (same clock as FIFO R_CLK).
- RST  input  1  asynchronous, active-low reset.
- EN  input  1  enable draining; sampled only in IDLE.
- FLUSH  input  1  discard mode; sampled only in IDLE; has priority over EN.
- FIFO_EMPTY  input  1  FIFO EMPTY flag.
- FIFO_RD_DATA  input  DATA_WIDTH  FIFO read data, valid whenever FIFO_EMPTY=0.
- FIFO_R_INC  output  1  one-cycle pop pulse to the FIFO.
- TX_BUSY  input  1  transmitter busy.
- TX_DATA  output  DATA_WIDTH  word to transmit.
- TX_DATA_VALID  output  1  request to transmitter.
- CTRL_BUSY  output  1  high whenever state is not IDLE.
- GAP_CFG  input  GAP_WIDTH  idle cycles between words (present only with DRAIN_GAP_EN).

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-low.
- Reset: state=IDLE. FIFO_R_INC=0, TX_DATA=0, TX_DATA_VALID=0, CTRL_BUSY=0, gap counter=0.
- Registered outputs: all outputs are registered, with no combinational paths from inputs to outputs.
- States: IDLE, SEND, WAIT_DONE, DROP, and GAP (GAP exists only with DRAIN_GAP_EN). 2-bit or 3-bit encoding comes from the package.
- IDLE:
  - FLUSH=1 and FIFO_EMPTY=0: pulse FIFO_R_INC, go to DROP. TX_DATA is not updated.
  - Else EN=1 and FIFO_EMPTY=0: on the same edge, TX_DATA<=FIFO_RD_DATA, FIFO_R_INC<=1 and TX_DATA_VALID<=1, then go to SEND.
  - Else stay in IDLE.
- FIFO_R_INC pulse: always exactly 1 cycle and cleared on the next edge. There is never more than one pop per word.
- SEND: hold TX_DATA_VALID=1 and keep TX_DATA stable. When TX_BUSY=1 is sampled, clear TX_DATA_VALID and go to WAIT_DONE.
- WAIT_DONE: when TX_BUSY=0 is sampled, go to IDLE (or to GAP with the feature enabled and GAP_CFG≠0).
- DROP: unconditional return to IDLE the next cycle.
  - This gives a minimum of 2 cycles between pops, which covers the one-edge EMPTY update after a pop.
  - Continuous FLUSH therefore pops one word per 2 cycles until EMPTY.
- Latency: pop to TX_DATA_VALID is 0 cycles (same edge). The minimum word period is 4 cycles for IDLE→SEND→WAIT_DONE→IDLE with a 1-cycle busy response.
- Mid-transfer changes: EN or FLUSH deasserted mid-transfer has no effect; the current word always completes.
- FIFO becoming empty mid-transfer: no effect.
- Stale busy: TX_BUSY already high in IDLE is ignored. SEND waits for TX_BUSY=1 as sampled, so a busy that is still high from the previous word is accepted as the acknowledgement. The transmitter must drop busy before WAIT_DONE exits, which the transmitter guarantees.
- Reset asserted mid-operation: immediate return to reset values. A word already popped but not yet sent is lost, which is acceptable.
- CTRL_BUSY: equals (next_state≠IDLE), registered.

Optional Feature:
- Macro: DRAIN_GAP_EN.
- Defined:
  - The GAP_CFG port exists.
  - After WAIT_DONE, the controller enters GAP, loads the counter with GAP_CFG and decrements it to 0.
  - It returns to IDLE on the cycle the counter is 1. This gives exactly GAP_CFG extra cycles, all with CTRL_BUSY=1.
  - GAP_CFG=0 skips GAP.
  - GAP_CFG is sampled on entry to GAP.
- Undefined: no GAP_CFG port, no GAP state and no counter logic; behaviour is identical to GAP_CFG=0.

Decomposition:
- Package fifo_drain_pkg holds:
  - the state enum/localparams IDLE, SEND, WAIT_DONE, DROP and GAP;
  - the default DATA_WIDTH.
- One sub-module, fifo_drain_gap_cnt: a loadable down-counter with a done flag, instantiated only under DRAIN_GAP_EN.
- The FSM and data register stay in the top.

Test Plan:
- Reset with FIFO holding 0xA5, EN=0 → all outputs 0; no pop while EN=0. Raise EN → FIFO_R_INC high 1 cycle, TX_DATA=0xA5, TX_DATA_VALID=1.
- Back-to-back words 0x11, 0x22, 0x33; TX_BUSY rises 1 cycle after valid and lasts 10 cycles → exactly 3 pops, TX_DATA sequence 0x11, 0x22, 0x33, valid clears on the busy-sampled edge. After the third word, EMPTY=1 → IDLE, CTRL_BUSY=0.
- FLUSH=1 with 5 words queued, EN=1 → 5 pops spaced 2 cycles apart, TX_DATA_VALID never asserted, TX_DATA unchanged.
- EN dropped during SEND for word 0x7E → word still sent, no further pop afterwards.
- RST asserted in WAIT_DONE → outputs zero asynchronously. After release with FIFO non-empty and EN=1 → a fresh pop occurs on the first active edge.
- DRAIN_GAP_EN with GAP_CFG=3 → exactly 3 cycles between TX_BUSY falling and the next FIFO_R_INC beyond the no-gap timing. With GAP_CFG=0, timing is identical to the no-macro build.
